serial_subtractor: RTL and testbench

- Bit-serial, multi-cycle subtractor; computes diff = a - b - bin one bit per clock, LSB first, through a single registered borrow stage.
- Inverse-direction counterpart to the team's ripple-carry adder datapath. Serves area-constrained paths where WIDTH-cycle latency is acceptable.
- Start/busy/done handshake toward the controlling FSM.

---
 rtl/serial_subtractor.sv | 136 +++++++++++++
 tb/tb_serial_subtractor.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, one bit per clock (optional ovf via SERIAL_SUBTRACTOR_OVF_EN)
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic             x, y, d_bit, br_next;
    logic [WIDTH-1:0] res_next;

    // One full-subtractor cell shared across all bit positions
    assign x        = a_sh_q[0];
    assign y        = b_sh_q[0];
    assign d_bit    = x ^ y ^ borrow_q;
    assign br_next  = (~x & y) | (~(x ^ y) & borrow_q);
    assign res_next = {d_bit, res_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        cnt_d    = cnt_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_d    = res_next;
                borrow_d = br_next;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    diff_d  = res_next;
                    bout_d  = br_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Acceptance is legal whenever busy is low, including the DONE cycle
        if ((state_q == IDLE || state_q == DONE) && start) begin
            state_d  = SHIFT;
            a_sh_d   = a;
            b_sh_d   = b;
            borrow_d = bin;
            cnt_d    = '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb_d  = a[WIDTH-1];
            b_msb_d  = b[WIDTH-1];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            cnt_q    <= cnt_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed scoreboard bench for serial_subtractor
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         bin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, bout;
    logic [W-1:0] diff;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        logic [W:0] full;
        exp_t       e;
        full   = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        e.diff = full[W-1:0];
        e.bout = full[W];
        e.ovf  = (ma[W-1] != mb[W-1]) && (e.diff[W-1] != ma[W-1]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while idle or in DONE; returns at the first busy negedge
    task automatic launch(input logic [W-1:0] la, input logic [W-1:0] lb, input logic lbin);
        start = 1'b1;
        a     = la;
        b     = lb;
        bin   = lbin;
        sb.push_back(model(la, lb, lbin));
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
    endtask

    task automatic finish_op(input int lat0);
        int   lat;
        int   bc;
        exp_t e;
        lat = lat0;
        bc  = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            lat++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("latency", lat, W + 1);
        chk("busy_cycles", bc, W + 1 - lat0);
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("diff", 32'(diff), 32'(e.diff));
            chk("bout", 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
        end
    endtask

    task automatic end_done();
        @(negedge clk);
        chk("done_pulse_end", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int ndone;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        launch(4'd9, 4'd3, 1'b0);   finish_op(1); end_done();
        launch(4'd3, 4'd9, 1'b0);   finish_op(1); end_done();
        launch(4'd0, 4'd0, 1'b1);   finish_op(1); end_done();
        launch(4'd15, 4'd15, 1'b0); finish_op(1); end_done();
        launch(4'd8, 4'd1, 1'b0);   finish_op(1); end_done();
        launch(4'd5, 4'd2, 1'b0);   finish_op(1); end_done();
        launch(4'd7, 4'd8, 1'b1);   finish_op(1); end_done();

        for (int i = 0; i < 6; i++) begin
            launch(W'($urandom), W'($urandom), 1'($urandom));
            finish_op(1);
            end_done();
        end

        // Start raised mid-operation must be ignored
        launch(4'd9, 4'd3, 1'b0);
        @(negedge clk);
        start = 1'b1;
        a     = 4'd1;
        b     = 4'd1;
        @(negedge clk);
        start = 1'b0;
        finish_op(3);

        // Back-to-back: new start during the DONE cycle
        launch(4'd2, 4'd7, 1'b1);
        finish_op(1);
        launch(4'd14, 4'd6, 1'b0);
        finish_op(1);
        end_done();

        // Reset mid-shift discards the operation
        launch(4'd9, 4'd3, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_diff", 32'(diff), 32'd0);
        chk("midrst_bout", 32'(bout), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("no_done_after_rst", ndone, 0);

        launch(4'd12, 4'd5, 1'b1);
        finish_op(1);
        end_done();
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
